// File: rtl/kakacpu_pkg.sv
// kakacpu_pkg: constants and types shared by the kakacpu decode/execute blocks.
//   OPERAND_WIDTH             - integer register / operand width
//   REGISTER_DESCRIPTOR_WIDTH - architectural register address width
//   PENDING_WIDTH             - default width of a per-register pending counter
//   pending_t                 - pending counter type at the default width
package kakacpu_pkg;

    localparam int OPERAND_WIDTH             = 32;
    localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
    localparam int PENDING_WIDTH             = 2;

    typedef logic [PENDING_WIDTH-1:0] pending_t;

endpackage

// File: rtl/scoreboard_register_file_pending_counter.sv
// pending_counter: saturating up/down counter of outstanding writes to one register.
//   clk, rst   - clock, asynchronous active-low reset
//   inc, dec   - count up / count down; both together leave the count unchanged
//   count      - current number of outstanding writes
//   max        - count is at its saturation value
module pending_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             max
);

    assign max = (count == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec && !max) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: integer register file with a per-register count of
// in-flight writes. Issue is held off until every used source operand has no
// outstanding write (or is being written back with its last one, when bypass
// is enabled) and the destination counter has room.
//   clk, rst              - clock, asynchronous active-low reset
//   issue_valid/ready     - decode handshake; ready is combinational
//   rs_addr/rs_used       - per-port source address and operand-needed flag
//   rs_data               - per-port operand value (x0 reads 0)
//   rd_write/rd_addr      - destination of the presented instruction
//   wb_valid/addr/data    - write-back strobe, never stalled
//   busy                  - bit r set while register r has outstanding writes
//   wb_error              - one-cycle pulse after a write-back with nothing pending
module scoreboard_register_file
    import kakacpu_pkg::*;
#(
    parameter int DATA_WIDTH    = OPERAND_WIDTH,
    parameter int REG_COUNT     = 32,
    parameter int ADDR_WIDTH    = REGISTER_DESCRIPTOR_WIDTH,
    parameter int READ_PORTS    = 2,
    parameter int PENDING_WIDTH = kakacpu_pkg::PENDING_WIDTH,
    parameter int BYPASS        = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rs_addr,
    input  logic [READ_PORTS-1:0]            rs_used,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rs_data,
    input  logic                             rd_write,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0]            wb_data,
    output logic [REG_COUNT-1:0]             busy,
    output logic                             wb_error
);

    logic [DATA_WIDTH-1:0]    regs [REG_COUNT];
    logic [PENDING_WIDTH-1:0] pend [REG_COUNT];
    logic [REG_COUNT-1:0]     pend_max;

    logic                     issue_fire;
    logic                     wb_legal;
    logic                     wb_illegal;
    logic                     ops_ready;
    logic                     dest_ok;
    logic [ADDR_WIDTH-1:0]    rs;
    logic                     byp;

    // x0 has no counter; it is permanently idle.
    assign pend[0]     = '0;
    assign pend_max[0] = 1'b0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue_fire && rd_write && (rd_addr == ADDR_WIDTH'(r));
        assign dec = wb_legal && (wb_addr == ADDR_WIDTH'(r));

        pending_counter #(
            .WIDTH (PENDING_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc),
            .dec   (dec),
            .count (pend[r]),
            .max   (pend_max[r])
        );
    end

    assign wb_legal   = wb_valid && (wb_addr != '0) && (pend[wb_addr] != '0);
    assign wb_illegal = wb_valid && (wb_addr != '0) && (pend[wb_addr] == '0);

    // A saturated destination can still accept when a legal write-back to the
    // same register frees a slot in the same cycle.
    assign dest_ok = !rd_write || (rd_addr == '0) || !pend_max[rd_addr] ||
                     (wb_legal && (wb_addr == rd_addr));

    assign issue_ready = ops_ready && dest_ok;
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        ops_ready = 1'b1;
        rs_data   = '0;
        rs        = '0;
        byp       = 1'b0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            rs  = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            // Forward only the last outstanding write; earlier ones are stale.
            byp = (BYPASS != 0) && wb_valid && (wb_addr == rs) &&
                  (pend[rs] == PENDING_WIDTH'(1));
            if (rs_used[i] && (rs != '0) && (pend[rs] != '0) && !byp) begin
                ops_ready = 1'b0;
            end
            if (rs == '0) begin
                rs_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (byp) begin
                rs_data[i*DATA_WIDTH +: DATA_WIDTH] = wb_data;
            end else begin
                rs_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[rs];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            busy[r] = (pend[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_legal) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_error <= 1'b0;
        end else begin
            wb_error <= wb_illegal;
        end
    end

endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised integer register file with a built-in per-register scoreboard, replacing the single-reservation-bit register file between decode and execution. It tracks how many in-flight writes target each register and gates issue until every source operand is available. Write-back data can be forwarded to the read ports in the same cycle. It serves `READ_PORTS` source operands per issued instruction.

## Interface
Parameters:
- `DATA_WIDTH`, default `OPERAND_WIDTH` (32): register width.
- `REG_COUNT`, default 32: number of architectural registers; register 0 is hardwired zero.
- `ADDR_WIDTH`, default `REGISTER_DESCRIPTOR_WIDTH` (5): equals clog2(`REG_COUNT`).
- `READ_PORTS`, default 2: number of source operands per issue, 1..4.
- `PENDING_WIDTH`, default 2: width of each pending counter; at most 2^`PENDING_WIDTH`-1 outstanding writes per register.
- `BYPASS`, default 1: 1 forwards write-back data to same-cycle reads; 0 disables forwarding.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low. Ports are `clk` and `rst`, named as the codebase names them.
  - `clk`  in  1  clock.
  - `rst`  in  1  asynchronous reset, active-low.
- Issue side:
  - `issue_valid`  in  1  decode presents an instruction.
  - `issue_ready`  out  1  all operands are available and the destination counter is not saturated.
  - `rs_addr`  in  `READ_PORTS*ADDR_WIDTH`  source addresses; port i is slice i.
  - `rs_used`  in  `READ_PORTS`  per-port operand-needed flag.
  - `rs_data`  out  `READ_PORTS*DATA_WIDTH`  operand values.
  - `rd_write`  in  1  instruction writes a destination register.
  - `rd_addr`  in  `ADDR_WIDTH`  destination address.
- Write-back side:
  - `wb_valid`  in  1  write-back strobe.
  - `wb_addr`  in  `ADDR_WIDTH`  write-back address.
  - `wb_data`  in  `DATA_WIDTH`  write-back value.
- Status:
  - `busy`  out  `REG_COUNT`  bit r is set when pending[r] != 0.
  - `wb_error`  out  1  registered one-cycle pulse on an illegal write-back.

## Operation
- Issue acceptance:
  - An issue is accepted when `issue_valid` && `issue_ready`.
  - On an accepted issue with `rd_write`=1 and `rd_addr`!=0, pending[`rd_addr`] increments.
- Operand availability:
  - Operand i is ready if `rs_used`[i]=0, or rs=0, or pending[rs]=0.
  - With `BYPASS`=1, operand i is also ready if `wb_valid` && `wb_addr`==rs && pending[rs]==1.
- `issue_ready` is the AND of all operand-ready terms and a destination term.
  - The destination term is true when pending[`rd_addr`] is below max.
  - It is also true when pending[`rd_addr`] is at max and a legal write-back to the same register occurs in the same cycle.
  - `issue_ready` is combinational. It does not depend on `issue_valid`.
- Operand read:
  - `rs_data`[i] is 0 when rs=0.
  - Otherwise it is `wb_data` when the bypass condition for port i holds.
  - Otherwise it is regs[rs].
- Write-back:
  - `wb_valid` with `wb_addr`!=0 and pending[`wb_addr`]>0 writes regs[`wb_addr`] and decrements the counter.
  - `wb_addr`=0 is ignored silently.
  - `wb_valid` to a register with pending=0 is illegal: regs and the counter are unchanged, and `wb_error` pulses the next cycle.
- Simultaneous increment and decrement of the same register leave its counter unchanged.
- Write-back never stalls and has no ready signal.

## Timing
- Reset values:
  - All regs = 0 and all pending counters = 0.
  - `busy` = 0 and `wb_error` = 0.
  - After reset, `rs_data` reads 0 and `issue_ready` = 1.
- Reset asserted mid-operation clears all state immediately. In-flight write-backs after release count as illegal if their counter is 0.
- Write-back latency:
  - Register-array data is visible on `rs_data` one cycle after the `wb_valid` edge.
  - With `BYPASS`=1, it is also visible in the same cycle.
- An issue accepted at edge N sets `busy`[rd] after edge N. A dependent instruction sees `issue_ready`=0 from cycle N+1.
- With `BYPASS`=0, a dependent operand becomes ready the cycle after its last write-back.

## Structure
- Shared package `kakacpu_pkg` holds `OPERAND_WIDTH`, `REGISTER_DESCRIPTOR_WIDTH`, and a `pending_t` typedef parameterised through `PENDING_WIDTH`.
- Sub-module `pending_counter` is a saturating up/down counter with inc and dec inputs, a `count` output, and a `max` flag. It is instantiated `REG_COUNT`-1 times.
- The register array and bypass multiplexers live in the top module.

## Test plan
- Reset then read x5 and x0 -> `rs_data`=0 on both ports, `issue_ready`=1, `busy`=0.
- Issue `rd_write` x3, then a dependent read of x3 -> `issue_ready`=0.
  - Then `wb_valid` x3 = 0xDEADBEEF with `BYPASS`=1 -> `issue_ready`=1 and `rs_data`=0xDEADBEEF in the same cycle.
- With `BYPASS`=0, same sequence -> `issue_ready` rises one cycle after the write-back.
- `PENDING_WIDTH`=2: three issues to x7 -> `issue_ready`=0 for a fourth issue to x7.
  - A fourth issue with a same-cycle write-back to x7 is accepted, and the counter stays at 3.
- `wb_valid` to x9 with pending=0 -> x9 unchanged and `wb_error`=1 for exactly one cycle.
- Two writes pending on x4, then reset asserted -> `busy`=0 immediately; a later write-back to x4 -> `wb_error` pulse.
